// File: rtl/alu_pkg.sv
// Shared ALU op codes and execute-stage state encoding.
// Imported by the ALU controller, alu_iter_exec and its benches.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLT = 4'b1100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter; amt never exceeds the iteration step.
module alu_shift_step #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] amt,
  input  logic          left,
  input  logic          arith,
  input  logic          sign,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] fill;

  // Arithmetic right shifts refill from the sign captured at accept.
  assign fill = (arith && sign) ? ~({DW{1'b1}} >> amt) : '0;
  assign dout = left ? (din << amt) : ((din >> amt) | fill);
endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/add/compare, iterative shifter for shifts.
// Define ALU_FASTSHIFT_EN to replace the iterative shifter with a barrel shifter.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int SHIFT_STEP    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     busy
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  state_t          state;
  logic [3:0]      op;
  logic [SW-1:0]   shamt;
  logic            is_shift, accept, go_shift;
  logic [DATA_WIDTH-1:0] comb_res, work, shifted;
  logic [CW-1:0]   remaining, step_amt;
  logic            sh_left, sh_arith, sh_sign;

  assign op       = 4'(Operation);
  assign shamt    = SrcB[SW-1:0];
  assign is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign step_amt = (remaining < STEP) ? remaining : STEP;

  always_comb begin
    comb_res = '0;
    case (op)
      ALU_AND: comb_res = SrcA & SrcB;
      ALU_OR:  comb_res = SrcA | SrcB;
      ALU_ADD: comb_res = SrcA + SrcB;
      ALU_XOR: comb_res = SrcA ^ SrcB;
      ALU_EQ:  comb_res = DATA_WIDTH'(SrcA == SrcB);
      ALU_SLT: comb_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
`ifdef ALU_FASTSHIFT_EN
      ALU_SLL: comb_res = SrcA << shamt;
      ALU_SRL: comb_res = SrcA >> shamt;
      ALU_SRA: comb_res = $signed(SrcA) >>> shamt;
`else
      // Only reached for a zero shift amount; longer shifts iterate.
      ALU_SLL, ALU_SRL, ALU_SRA: comb_res = SrcA;
`endif
      default: comb_res = '0;
    endcase
  end

`ifdef ALU_FASTSHIFT_EN
  assign go_shift = 1'b0;
  assign shifted  = work;
`else
  assign go_shift = is_shift && (shamt != '0);
  alu_shift_step #(.DW(DATA_WIDTH), .CW(CW)) u_step (
    .din  (work),
    .amt  (step_amt),
    .left (sh_left),
    .arith(sh_arith),
    .sign (sh_sign),
    .dout (shifted)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      Result    <= '0;
      busy      <= 1'b0;
      work      <= '0;
      remaining <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
      sh_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          // Accept in DONE only happens while out_ready drains the old result.
          if (accept) begin
            sh_left  <= (op == ALU_SLL);
            sh_arith <= (op == ALU_SRA);
            sh_sign  <= SrcA[DATA_WIDTH-1];
            if (go_shift) begin
              work      <= SrcA;
              remaining <= CW'(shamt);
              busy      <= 1'b1;
              out_valid <= 1'b0;
              state     <= SHIFT;
            end else begin
              Result    <= comb_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work      <= shifted;
          remaining <= remaining - step_amt;
          if (remaining == step_amt) begin
            Result    <= shifted;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: one DUT with SHIFT_STEP=1, one with SHIFT_STEP=4.
module tb_alu_iter_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv, iv4, ordy;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        ir, ov, bsy, ir4, ov4, bsy4;
  logic [31:0] res, res4;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alu_iter_exec #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .SHIFT_STEP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .Operation(op),
    .SrcA(a), .SrcB(b), .out_valid(ov), .out_ready(ordy), .Result(res), .busy(bsy)
  );

  alu_iter_exec #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .Operation(op),
    .SrcA(a), .SrcB(b), .out_valid(ov4), .out_ready(ordy), .Result(res4), .busy(bsy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op to an idle DUT, then measure latency, busy cycles and result.
  task automatic run(input bit sel, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input int elat, input int ebusy, input string tag);
    int  lat, bc;
    bit  done;
    op = o; a = x; b = y;
    if (sel) iv4 = 1'b1; else iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; iv4 = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom);
    lat = 0; bc = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (sel ? bsy4 : bsy) bc++;
      if (sel ? ov4 : ov) done = 1'b1;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy"}, bc, ebusy);
    chk({tag, "_res"}, sel ? res4 : res, er);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    reset = 1'b1; iv = 1'b0; iv4 = 1'b0; ordy = 1'b1; op = '0; a = '0; b = '0;
    @(negedge clk);
    chk("rst_ov", ov, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_res", res, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ir, 1);
    @(posedge clk); #1;

    // Reset in the middle of a long shift discards it.
    op = ALU_SRL; a = 32'hFFFF0000; b = 32'd31; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", bsy, 1);
    chk("mid_ready", ir, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ov", ov, 0);
    chk("mid_rst_busy", bsy, 0);
    chk("mid_rst_ready", ir, 1);
    chk("mid_rst_res", res, 0);
    seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (ov) seen++;
    end
    chk("mid_no_stale", seen, 0);
    @(posedge clk); #1;

    run(0, ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, "add_ovf");
    run(0, ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, "add_wrap");
    run(0, ALU_SRA, 32'h80000000, 32'd4,        32'hF8000000, 5, 4, "sra4_s1");
    run(1, ALU_SRA, 32'h80000000, 32'd4,        32'hF8000000, 2, 1, "sra4_s4");
    run(1, ALU_SLL, 32'h00000003, 32'd6,        32'h000000C0, 3, 2, "sll6_s4");
    run(0, ALU_SLL, 32'h00000001, 32'd0,        32'h00000001, 1, 0, "sll0");
    run(0, ALU_SLL, 32'h00000001, 32'd31,       32'h80000000, 32, 31, "sll31");
    run(0, ALU_EQ,  32'h00001234, 32'h00001234, 32'h00000001, 1, 0, "eq_t");
    run(0, ALU_EQ,  32'h00001234, 32'h00001235, 32'h00000000, 1, 0, "eq_f");
    run(0, 4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1, 0, "undef");
    run(0, ALU_AND, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1, 0, "and");
    run(0, ALU_OR,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1, 0, "or");

    // Backpressure: result held while out_ready is low, then back-to-back accept.
    ordy = 1'b0;
    op = ALU_XOR; a = 32'hA5A5A5A5; b = 32'hFFFFFFFF; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ov", ov, 1);
      chk("bp_res", res, 32'h5A5A5A5A);
      chk("bp_ready", ir, 0);
    end
    @(posedge clk); #1;
    ordy = 1'b1; iv = 1'b1; op = ALU_SLT; a = 32'hFFFFFFFF; b = 32'h00000001;
    @(negedge clk);
    chk("b2b_ready", ir, 1);
    chk("b2b_old_res", res, 32'h5A5A5A5A);
    @(posedge clk); #1;
    iv = 1'b0; a = 32'h0; b = 32'h0;
    @(negedge clk);
    chk("b2b_ov", ov, 1);
    chk("b2b_slt", res, 32'h00000001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_drain", ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execute-stage ALU directly downstream of the ALU controller. It consumes the 4-bit Operation code and two operands under a valid/ready handshake.
- Logic, add and compare ops complete in one registered cycle.
- Shifts run on an iterative shifter, SHIFT_STEP bits per cycle, so a multi-cycle ALU can stall the pipeline instead of needing a full barrel shifter.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, width of Operation.
- SHIFT_STEP, 1, bit positions shifted per iteration cycle; legal range 1..DATA_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and Operation valid.
- in_ready  out  1  block accepts operands this cycle.
- Operation  in  OPCODE_LENGTH  op select from ALU controller.
- SrcA  in  DATA_WIDTH  operand A.
- SrcB  in  DATA_WIDTH  operand B; shift amount is SrcB[$clog2(DATA_WIDTH)-1:0].
- out_valid  out  1  Result valid.
- out_ready  in  1  consumer takes Result this cycle.
- Result  out  DATA_WIDTH  registered result.
- busy  out  1  shift iteration in progress.

Behaviour:
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD (wraps mod 2^DATA_WIDTH, no carry out), 1001 XOR.
  - 0100 SLL, 0101 SRL, 0111 SRA.
  - 1000 EQ: Result = (SrcA==SrcB) ? 1 : 0.
  - 1100 SLT, signed: Result = 1 or 0.
  - Any other code: Result = 0, single-cycle.
- Reset: state=IDLE, out_valid=0, Result=0, busy=0, internal shift count=0. Reset mid-shift or with an output pending discards it; in_ready=1 in the cycle after reset deasserts.
- States:
  - IDLE: in_ready=1.
    - Accept on in_valid&&in_ready.
    - Non-shift op, or shift with shamt==0 → DONE, Result loaded at the accepting edge.
    - Shift with shamt>0 → SHIFT: working register=SrcA, remaining=shamt.
  - SHIFT: busy=1, in_ready=0.
    - Each cycle shift by min(SHIFT_STEP, remaining) and decrement remaining.
    - SRA fills with the latched sign bit.
    - When remaining reaches 0, load Result → DONE.
  - DONE: out_valid=1; Result and out_valid held stable until out_ready.
    - out_ready&&!in_valid → IDLE.
    - out_ready&&in_valid: in_ready=1 in DONE while out_ready=1, and the new op is accepted in the same cycle (back-to-back, no bubble).
- Latency from the accept edge T:
  - Non-shift op: out_valid at T+1.
  - Shift: out_valid at T+1+ceil(shamt/SHIFT_STEP).
- Throughput: 1 op/cycle for non-shift ops when out_ready is held high.
- Operation and operands are latched at accept; the inputs may change afterwards without effect.
- in_valid while in_ready=0 is ignored. The upstream stage holds its inputs until accepted.

Optional Feature:
- Macro ALU_FASTSHIFT_EN.
- Defined: shifts use a combinational barrel shifter. SHIFT state is never entered, busy is tied 0, all ops have 1-cycle latency, and SHIFT_STEP is unused.
- Undefined: iterative shifter as described above.

Decomposition:
- Shared package alu_pkg:
  - Operation code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SRA, ALU_EQ, ALU_XOR, ALU_SLT).
  - State enum typedef (IDLE, SHIFT, DONE).
  - Also imported by the ALU controller and the benches.
- One sub-module, alu_shift_step: combinational single-step shifter (dir, arith, amount ≤ SHIFT_STEP). It is instantiated once in the iterative path.

Test Plan:
- Reset held 2 cycles during SHIFT of SRL 0xFFFF0000 by 31 → out_valid=0, busy=0, in_ready=1 after release; no stale Result.
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 → out_valid at T+1, Result=0x80000000. ADD 0xFFFFFFFF+1 → 0x00000000.
- SRA 0x80000000 by 4, SHIFT_STEP=1 → busy 4 cycles, out_valid at T+5, Result=0xF8000000. Same op with SHIFT_STEP=4 → out_valid at T+2.
- SLL 0x00000001 by 0 → out_valid at T+1, Result=0x00000001, busy never asserted.
- Backpressure: XOR 0xA5A5A5A5^0xFFFFFFFF with out_ready=0 for 3 cycles → Result=0x5A5A5A5A held stable, in_ready=0. Then out_ready=1 with in_valid and SLT 0xFFFFFFFF<0x00000001 → accepted same cycle, next Result=1.
- EQ 0x1234 vs 0x1234 → 1; EQ 0x1234 vs 0x1235 → 0; undefined code 1111 → Result=0 at T+1.
